// File: rtl/lut_neuron_scheduler.sv
// Time-multiplexes one shared LUT-neuron slot across NUM_NEURONS logical neurons:
// issues indices 0..N-1 one per cycle, gathers delayed results, presents the layer vector.
module lut_neuron_scheduler #(
  parameter int NUM_NEURONS = 8,
  parameter int IN_W        = 32,
  parameter int OUT_BW      = 2,
  parameter int LUT_LAT     = 1,
  localparam int IDX_W      = $clog2(NUM_NEURONS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_W-1:0]               in_data,
  output logic [IN_W-1:0]               in_hold,
  output logic                          nrn_issue,
  output logic [IDX_W-1:0]              nrn_idx,
  input  logic [OUT_BW-1:0]             lut_q,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_NEURONS*OUT_BW-1:0] out_data,
  output logic                          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  state_t           state, state_nxt;
  logic             accept;
  logic             tail_v;
  logic [IDX_W-1:0] tail_idx;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    nrn_issue = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        nrn_issue = 1'b1;
        if (nrn_idx == LAST_IDX) state_nxt = (LUT_LAT == 0) ? DONE : DRAIN;
      end
      // the last issued neuron reaching the tail marks the final write
      DRAIN: if (tail_v && tail_idx == LAST_IDX) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // {issue, idx} delay line aligning each result with the neuron that produced it
  generate
    if (LUT_LAT == 0) begin : g_comb
      assign tail_v   = nrn_issue;
      assign tail_idx = nrn_idx;
    end else begin : g_pipe
      logic [LUT_LAT-1:0]            vld_pipe;
      logic [LUT_LAT-1:0][IDX_W-1:0] idx_pipe;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_pipe <= '0;
          idx_pipe <= '0;
        end else begin
          vld_pipe[0] <= nrn_issue;
          idx_pipe[0] <= nrn_idx;
          for (int i = 1; i < LUT_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            idx_pipe[i] <= idx_pipe[i-1];
          end
        end
      end

      assign tail_v   = vld_pipe[LUT_LAT-1];
      assign tail_idx = idx_pipe[LUT_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      in_hold  <= '0;
      nrn_idx  <= '0;
      out_data <= '0;
    end else begin
      if (accept) begin
        in_hold <= in_data;
        nrn_idx <= '0;
      end else if (nrn_issue && nrn_idx != LAST_IDX) begin
        nrn_idx <= nrn_idx + 1'b1;
      end
      // lut_q is only trusted on tail-issue edges
      if (accept)      out_data <= '0;
      else if (tail_v) out_data[tail_idx*OUT_BW +: OUT_BW] <= lut_q;
    end
  end

endmodule

// File: tb/tb_lut_neuron_scheduler.sv
// Directed bench: three scheduler configurations (N4/L0, N4/L2, N5/L3) driven by a simple slot model.
module tb_lut_neuron_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  // instance a: N=4, LUT_LAT=0
  logic       a_in_valid, a_in_ready, a_nrn_issue, a_out_valid, a_out_ready, a_busy;
  logic [3:0] a_in_data, a_in_hold;
  logic [1:0] a_nrn_idx, a_lut_q;
  logic [7:0] a_out_data;

  // instance b: N=4, LUT_LAT=2
  logic       b_in_valid, b_in_ready, b_nrn_issue, b_out_valid, b_out_ready, b_busy;
  logic [3:0] b_in_data, b_in_hold;
  logic [1:0] b_nrn_idx, b_lut_q;
  logic [7:0] b_out_data;

  // instance c: N=5, LUT_LAT=3
  logic       c_in_valid, c_in_ready, c_nrn_issue, c_out_valid, c_out_ready, c_busy;
  logic [4:0] c_in_data, c_in_hold;
  logic [2:0] c_nrn_idx;
  logic [1:0] c_lut_q;
  logic [9:0] c_out_data;

  lut_neuron_scheduler #(.NUM_NEURONS(4), .IN_W(4), .OUT_BW(2), .LUT_LAT(0)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_hold(a_in_hold), .nrn_issue(a_nrn_issue), .nrn_idx(a_nrn_idx), .lut_q(a_lut_q),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy));

  lut_neuron_scheduler #(.NUM_NEURONS(4), .IN_W(4), .OUT_BW(2), .LUT_LAT(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_hold(b_in_hold), .nrn_issue(b_nrn_issue), .nrn_idx(b_nrn_idx), .lut_q(b_lut_q),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy));

  lut_neuron_scheduler #(.NUM_NEURONS(5), .IN_W(5), .OUT_BW(2), .LUT_LAT(3)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .in_hold(c_in_hold), .nrn_issue(c_nrn_issue), .nrn_idx(c_nrn_idx), .lut_q(c_lut_q),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .busy(c_busy));

  // slot model: result = in_hold bit replicated; 2'b10 garbage whenever no result is due
  logic [1:0] b_vp = '0;
  logic [3:0] b_qp = '0;
  logic [2:0] c_vp = '0;
  logic [5:0] c_qp = '0;

  assign a_lut_q = a_nrn_issue ? {2{a_in_hold[a_nrn_idx]}} : 2'b10;

  always @(posedge clk) begin
    b_vp <= {b_vp[0], b_nrn_issue};
    b_qp <= {b_qp[1:0], {2{b_in_hold[b_nrn_idx]}}};
    c_vp <= {c_vp[1:0], c_nrn_issue};
    c_qp <= {c_qp[3:0], {2{c_in_hold[c_nrn_idx]}}};
  end

  assign b_lut_q = b_vp[1] ? b_qp[3:2] : 2'b10;
  assign c_lut_q = c_vp[2] ? c_qp[5:4] : 2'b10;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int         first, width, cnt, bad, nacc, nout, found, maxidx;
  logic [7:0] seq;
  logic [31:0] dat;
  logic       took;
  int         acc [4];
  logic [3:0] vec [4]  = '{4'b1010, 4'b0101, 4'b1010, 4'b0101};
  logic [7:0] expv [4] = '{8'hCC, 8'h33, 8'hCC, 8'h33};

  initial begin
    rst = 1'b1;
    a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
    c_in_valid = 0; c_in_data = '0; c_out_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  32'(b_in_ready),  32'd1);
    chk("rst_busy",      32'(b_busy),      32'd0);
    chk("rst_out_valid", 32'(b_out_valid), 32'd0);
    chk("rst_issue",     32'(b_nrn_issue), 32'd0);
    chk("rst_idx",       32'(b_nrn_idx),   32'd0);
    chk("rst_out_data",  32'(b_out_data),  32'd0);
    chk("rst_c_data",    32'(c_out_data),  32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: LUT_LAT=0, single-cycle out_valid with out_ready held high
    a_out_ready = 1; a_in_valid = 1; a_in_data = 4'b1010;
    @(posedge clk); #1 a_in_valid = 0; a_in_data = 4'b0000;
    first = 0; width = 0; cnt = 0; dat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (a_nrn_issue) cnt++;
      if (a_out_valid) begin
        if (first == 0) first = c;
        width++;
        dat = 32'(a_out_data);
      end
    end
    chk("t1_latency", 32'(first), 32'd5);
    chk("t1_width",   32'(width), 32'd1);
    chk("t1_data",    dat,        32'hCC);
    chk("t1_issues",  32'(cnt),   32'd4);
    chk("t1_idle",    32'(a_in_ready), 32'd1);

    // 2: LUT_LAT=2, index sequence and latency
    @(posedge clk); #1 b_out_ready = 1; b_in_valid = 1; b_in_data = 4'b0110;
    @(posedge clk); #1 b_in_valid = 0;
    first = 0; width = 0; cnt = 0; dat = 0; seq = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (b_nrn_issue) begin seq = {seq[5:0], b_nrn_idx}; cnt++; end
      if (b_out_valid) begin
        if (first == 0) first = c;
        width++;
        dat = 32'(b_out_data);
      end
    end
    chk("t2_latency", 32'(first), 32'd7);
    chk("t2_width",   32'(width), 32'd1);
    chk("t2_data",    dat,        32'h3C);
    chk("t2_idx_seq", 32'(seq),   32'h1B);
    chk("t2_issues",  32'(cnt),   32'd4);

    // 3: backpressure in DONE; in_valid pulsed while busy must be ignored
    @(posedge clk); #1 b_out_ready = 0; b_in_valid = 1; b_in_data = 4'b1001;
    @(posedge clk); #1 b_in_valid = 0;
    first = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (b_out_valid) begin first = c; break; end
    end
    chk("t3_reach_done", 32'(first), 32'd7);
    b_in_valid = 1; b_in_data = 4'b0110;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (!b_out_valid || b_out_data !== 8'hC3 || b_in_ready || b_in_hold !== 4'b1001) bad++;
      @(negedge clk);
    end
    chk("t3_hold_stable", 32'(bad),        32'd0);
    chk("t3_data",        32'(b_out_data), 32'hC3);
    b_out_ready = 1; b_in_valid = 0;
    @(negedge clk);
    chk("t3_idle_in_ready",  32'(b_in_ready),  32'd1);
    chk("t3_idle_out_valid", 32'(b_out_valid), 32'd0);

    // 4: in_valid held high with alternating vectors -> back-to-back at max rate
    @(posedge clk); #1 b_in_valid = 1; b_in_data = vec[0];
    nacc = 0; nout = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (b_out_valid && nout < 4) begin
        chk($sformatf("t4_out%0d", nout), 32'(b_out_data), 32'(expv[nout]));
        nout++;
      end
      took = b_in_ready && b_in_valid;
      if (took && nacc < 4) begin acc[nacc] = cyc; nacc++; end
      @(posedge clk); #1;
      if (took) begin
        if (nacc >= 4) b_in_valid = 0;
        else           b_in_data  = vec[nacc];
      end
    end
    chk("t4_accepts", 32'(nacc), 32'd4);
    chk("t4_outputs", 32'(nout), 32'd4);
    chk("t4_space01", 32'(acc[1] - acc[0]), 32'd8);
    chk("t4_space12", 32'(acc[2] - acc[1]), 32'd8);
    chk("t4_space23", 32'(acc[3] - acc[2]), 32'd8);

    // 5: reset mid-ISSUE, then a clean transaction
    b_in_valid = 1; b_in_data = 4'b1111;
    @(posedge clk); #1 b_in_valid = 0;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (b_nrn_issue && b_nrn_idx == 2'd2) begin found = 1; break; end
    end
    chk("t5_reach_idx2", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy",      32'(b_busy),      32'd0);
    chk("t5_in_ready",  32'(b_in_ready),  32'd1);
    chk("t5_issue",     32'(b_nrn_issue), 32'd0);
    chk("t5_idx",       32'(b_nrn_idx),   32'd0);
    chk("t5_out_valid", 32'(b_out_valid), 32'd0);
    chk("t5_out_data",  32'(b_out_data),  32'd0);
    chk("t5_in_hold",   32'(b_in_hold),   32'd0);
    rst = 1'b0;
    @(posedge clk); #1 b_in_valid = 1; b_in_data = 4'b0001;
    @(posedge clk); #1 b_in_valid = 0;
    found = 0; dat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (b_out_valid) begin found = c; dat = 32'(b_out_data); break; end
    end
    chk("t5_next_latency", 32'(found), 32'd7);
    chk("t5_next_data",    dat,        32'h03);

    // 6: N=5, LUT_LAT=3
    @(posedge clk); #1 c_out_ready = 1; c_in_valid = 1; c_in_data = 5'b10001;
    @(posedge clk); #1 c_in_valid = 0;
    first = 0; cnt = 0; maxidx = 0; dat = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (int'(c_nrn_idx) > maxidx) maxidx = int'(c_nrn_idx);
      if (c_nrn_issue) cnt++;
      if (c_out_valid && first == 0) begin first = c; dat = 32'(c_out_data); end
    end
    chk("t6_latency", 32'(first),  32'd9);
    chk("t6_data",    dat,         32'h303);
    chk("t6_max_idx", 32'(maxidx), 32'd4);
    chk("t6_issues",  32'(cnt),    32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
